// File: rtl/row_entry_builder.sv
// row_entry_builder: collects key events into a 5-tile draft and submits it via valid/ready
module row_entry_builder #(
    parameter int MAX_GUESSES = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic        key_back,
    input  logic        key_enter,
    input  logic        new_game,
    input  logic        row_ready,
    input  logic        solved,
    output logic [34:0] row_out,
    output logic        row_valid,
    output logic [34:0] draft_row,
    output logic [2:0]  cursor,
    output logic [2:0]  guess_idx,
    output logic        game_over,
    output logic        err_short
);
    typedef enum logic [1:0] {EDIT, SUBMIT, DONE} state_t;
    state_t state, next_state;
    logic do_letter, do_back, do_submit, do_err, accept, finish;
    logic [5:0] wpos, bpos;
    always_comb begin
        accept = state == SUBMIT && row_valid && row_ready && !new_game;
        finish = accept && (solved || guess_idx == 3'(MAX_GUESSES - 1));
        do_submit = 1'b0;
        do_err = 1'b0;
        do_back = 1'b0;
        do_letter = 1'b0;
        if (state == EDIT && !new_game) begin
            if (key_enter) begin
                do_submit = cursor == 3'd5;
                do_err = cursor != 3'd5;
            end else if (key_back)
                do_back = cursor != 3'd0;
            else
                do_letter = key_valid && key_code >= 5'd1 && key_code <= 5'd26 && cursor < 3'd5;
        end
        next_state = new_game ? EDIT : do_submit ? SUBMIT : finish ? DONE : accept ? EDIT : state;
        // First letter lands in the leftmost tile (bits 34:28)
        wpos = 6'd28 - 6'(7 * cursor);
        bpos = wpos + 6'd7;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EDIT;
        else state <= next_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_out <= '0;
            row_valid <= 1'b0;
            draft_row <= '0;
            cursor <= '0;
            guess_idx <= '0;
            game_over <= 1'b0;
            err_short <= 1'b0;
        end else begin
            err_short <= do_err;
            if (new_game) begin
                draft_row <= '0;
                cursor <= '0;
                guess_idx <= '0;
                row_valid <= 1'b0;
                game_over <= 1'b0;
            end else begin
                if (do_letter) begin
                    draft_row[wpos +: 7] <= {2'b00, key_code};
                    cursor <= cursor + 3'd1;
                end
                if (do_back) begin
                    draft_row[bpos +: 7] <= 7'd0;
                    cursor <= cursor - 3'd1;
                end
                if (do_submit) begin
                    row_out <= draft_row;
                    row_valid <= 1'b1;
                end
                if (accept) begin
                    row_valid <= 1'b0;
                    draft_row <= '0;
                    cursor <= '0;
                    guess_idx <= guess_idx + 3'd1;
                    game_over <= finish;
                end
            end
        end
    end
endmodule

// File: tb/tb_row_entry_builder.sv
// tb_row_entry_builder: directed vectors with hand-computed expectations
module tb_row_entry_builder;
    logic clk = 0, rst_n = 1;
    logic key_valid = 0, key_back = 0, key_enter = 0, new_game = 0, row_ready = 0, solved = 0;
    logic [4:0] key_code = 0;
    logic [34:0] row_out, draft_row;
    logic row_valid, game_over, err_short;
    logic [2:0] cursor, guess_idx;
    int n_checks = 0, n_err = 0;
    logic [34:0] crane, held;

    row_entry_builder #(.MAX_GUESSES(6)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_back(key_back), .key_enter(key_enter), .new_game(new_game),
        .row_ready(row_ready), .solved(solved), .row_out(row_out), .row_valid(row_valid),
        .draft_row(draft_row), .cursor(cursor), .guess_idx(guess_idx),
        .game_over(game_over), .err_short(err_short)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic letter(input logic [4:0] c);
        key_valid = 1; key_code = c; tick(); key_valid = 0; key_code = 0;
    endtask

    task automatic back();
        key_back = 1; tick(); key_back = 0;
    endtask

    task automatic enter();
        key_enter = 1; tick(); key_enter = 0;
    endtask

    task automatic restart();
        new_game = 1; tick(); new_game = 0;
    endtask

    task automatic type_row(input logic [34:0] r);
        for (int i = 0; i < 5; i++) letter(r[7*(4-i) +: 5]);
    endtask

    task automatic submit_row(input logic [34:0] r, input logic s, input logic [2:0] g, input logic go);
        type_row(r);
        row_ready = 1; solved = s;
        enter();
        chk("sub_valid", {34'b0, row_valid}, 35'd1);
        chk("sub_row", row_out, r);
        tick();
        row_ready = 0; solved = 0;
        chk("acc_valid", {34'b0, row_valid}, 35'd0);
        chk("acc_guess", {32'b0, guess_idx}, {32'b0, g});
        chk("acc_over", {34'b0, game_over}, {34'b0, go});
    endtask

    initial begin
        crane = {7'd3, 7'd18, 7'd1, 7'd14, 7'd5};
        #1 rst_n = 0;
        #1;
        chk("rst_row", row_out, 0);
        chk("rst_draft", draft_row, 0);
        chk("rst_flags", {29'b0, row_valid, game_over, err_short, cursor}, 0);
        chk("rst_guess", {32'b0, guess_idx}, 0);
        #10 rst_n = 1;
        tick();

        type_row(crane);
        chk("crane_draft", draft_row, crane);
        chk("crane_cursor", {32'b0, cursor}, 35'd5);
        chk("crane_pre_valid", {34'b0, row_valid}, 0);
        enter();
        chk("crane_valid", {34'b0, row_valid}, 35'd1);
        chk("crane_row", row_out, crane);

        for (int i = 0; i < 4; i++) begin
            if (i == 0) letter(5'd7);
            else if (i == 1) back();
            else if (i == 2) enter();
            else tick();
            chk("hold_row", row_out, crane);
            chk("hold_valid", {34'b0, row_valid}, 35'd1);
            chk("hold_draft", draft_row, crane);
            chk("hold_err", {34'b0, err_short}, 0);
        end
        row_ready = 1; tick(); row_ready = 0;
        chk("acc1_valid", {34'b0, row_valid}, 0);
        chk("acc1_guess", {32'b0, guess_idx}, 35'd1);
        chk("acc1_draft", draft_row, 0);
        chk("acc1_cursor", {32'b0, cursor}, 0);

        letter(5'd24); letter(5'd25); letter(5'd26);
        chk("xyz_draft", draft_row, {7'd24, 7'd25, 7'd26, 14'd0});
        back(); back();
        chk("bk_cursor", {32'b0, cursor}, 35'd1);
        chk("bk_draft", draft_row, {7'd24, 28'd0});
        enter();
        chk("short_err", {34'b0, err_short}, 35'd1);
        chk("short_valid", {34'b0, row_valid}, 0);
        chk("short_draft", draft_row, {7'd24, 28'd0});
        tick();
        chk("short_err_off", {34'b0, err_short}, 0);
        back(); back();
        chk("bk0_cursor", {32'b0, cursor}, 0);
        chk("bk0_draft", draft_row, 0);

        for (int i = 1; i <= 6; i++) letter(5'(i));
        letter(5'd0); letter(5'd30);
        chk("sat_cursor", {32'b0, cursor}, 35'd5);
        chk("sat_draft", draft_row, {7'd1, 7'd2, 7'd3, 7'd4, 7'd5});
        chk("sat_err", {34'b0, err_short}, 0);
        back(); back(); back(); back(); back();

        submit_row({7'd19, 7'd20, 7'd1, 7'd18, 7'd5}, 0, 3'd2, 0);
        submit_row({7'd8, 7'd15, 7'd21, 7'd19, 7'd5}, 0, 3'd3, 0);
        submit_row({7'd12, 7'd9, 7'd7, 7'd8, 7'd20}, 0, 3'd4, 0);
        submit_row({7'd2, 7'd18, 7'd9, 7'd14, 7'd11}, 0, 3'd5, 0);
        held = {7'd16, 7'd12, 7'd1, 7'd14, 7'd11};
        submit_row(held, 0, 3'd6, 1);
        letter(5'd4);
        chk("done_cursor", {32'b0, cursor}, 0);
        chk("done_draft", draft_row, 0);
        enter();
        chk("done_valid", {34'b0, row_valid}, 0);
        chk("done_err", {34'b0, err_short}, 0);
        chk("done_row", row_out, held);
        chk("done_guess", {32'b0, guess_idx}, 35'd6);

        restart();
        chk("ng_over", {34'b0, game_over}, 0);
        chk("ng_guess", {32'b0, guess_idx}, 0);
        submit_row(crane, 0, 3'd1, 0);
        submit_row({7'd19, 7'd12, 7'd1, 7'd20, 7'd5}, 1, 3'd2, 1);

        restart();
        type_row(crane);
        enter();
        chk("pend_valid", {34'b0, row_valid}, 35'd1);
        row_ready = 1; new_game = 1; tick(); new_game = 0; row_ready = 0;
        chk("abandon_valid", {34'b0, row_valid}, 0);
        chk("abandon_guess", {32'b0, guess_idx}, 0);
        chk("abandon_cursor", {32'b0, cursor}, 0);
        chk("abandon_draft", draft_row, 0);

        letter(5'd1); letter(5'd2);
        #2 rst_n = 0;
        #1;
        chk("arst_draft", draft_row, 0);
        chk("arst_row", row_out, 0);
        chk("arst_flags", {29'b0, row_valid, game_over, err_short, cursor}, 0);
        #10 rst_n = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
